// File: rtl/fpu_arb_pkg.sv
// Shared constants for the two-channel add/subtract arbiter: FSM encoding,
// channel identifiers and the round-robin pick helper.
package fpu_arb_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_ACK_UNIT = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic CH_HOST   = 1'b0;
    localparam logic CH_CORDIC = 1'b1;

    // On contention the channel that was not served last wins.
    function automatic logic rr_pick(input logic req_0, input logic req_1, input logic last);
        if (req_0 && req_1) begin
            return ~last;
        end
        return req_1 ? CH_CORDIC : CH_HOST;
    endfunction

endpackage

// File: rtl/fpu_addsubt_arbiter_if.sv
// Bundle of requester-side and unit-side signals of the add/subtract arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface fpu_addsubt_arbiter_if #(parameter int W = 64);

    logic         beg_0, beg_1;
    logic         op_0, op_1;
    logic [W-1:0] dataA_0, dataB_0, dataA_1, dataB_1;
    logic         ack_0, ack_1;
    logic         ready_0, ready_1;
    logic [W-1:0] result_0, result_1;
    logic         ovf_0, unf_0, err_0, ovf_1, unf_1, err_1;

    logic         beg_fsm, rst_fsm, add_subt;
    logic [W-1:0] data_x, data_y;
    logic         ready_unit, ovf_unit, unf_unit;
    logic [W-1:0] result_unit;

    logic         busy, grant;

    modport slave (
        input  beg_0, beg_1, op_0, op_1, dataA_0, dataB_0, dataA_1, dataB_1,
        input  ack_0, ack_1, ready_unit, ovf_unit, unf_unit, result_unit,
        output ready_0, ready_1, result_0, result_1,
        output ovf_0, unf_0, err_0, ovf_1, unf_1, err_1,
        output beg_fsm, rst_fsm, add_subt, data_x, data_y, busy, grant
    );

    modport master (
        output beg_0, beg_1, op_0, op_1, dataA_0, dataB_0, dataA_1, dataB_1,
        output ack_0, ack_1, ready_unit, ovf_unit, unf_unit, result_unit,
        input  ready_0, ready_1, result_0, result_1,
        input  ovf_0, unf_0, err_0, ovf_1, unf_1, err_1,
        input  beg_fsm, rst_fsm, add_subt, data_x, data_y, busy, grant
    );

endinterface

// File: rtl/arb_timeout_counter.sv
// Watchdog for the WAIT state: tc rises on the TIMEOUT-th enabled cycle
// after a clear, and the count then holds there.
module arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/d_ff_en.sv
// Enabled register with asynchronous active-low clear, used for operand
// and per-channel result storage.
module d_ff_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fpu_addsubt_arbiter.sv
// Two-channel round-robin arbiter in front of a shared IEEE-754 add/subtract
// unit: one transaction at a time, results held per channel until acknowledged.
module fpu_addsubt_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int W       = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_addsubt_arbiter_if.slave  bus
);

    logic [2:0]   state_q, state_d;
    logic         grant_q, grant_d;
    logic         pick;
    logic         load_op;
    logic         cap_0, cap_1;
    logic         cnt_clr, cnt_en, tc;
    logic [2*W:0] op_d, op_q;
    logic [W+2:0] cap_word;
    logic [W+2:0] res0_q, res1_q;

    assign pick = rr_pick(bus.beg_0, bus.beg_1, grant_q);
    assign op_d = pick ? {bus.op_1, bus.dataA_1, bus.dataB_1}
                       : {bus.op_0, bus.dataA_0, bus.dataB_0};

    // A timeout captures a zero result with only err set.
    assign cap_word = bus.ready_unit ? {bus.result_unit, bus.ovf_unit, bus.unf_unit, 1'b0}
                                     : {{W{1'b0}}, 3'b001};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        load_op = 1'b0;
        cap_0   = 1'b0;
        cap_1   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.beg_0 || bus.beg_1) begin
                    grant_d = pick;
                    load_op = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (bus.ready_unit || tc) begin
                    cap_0   = (grant_q == CH_HOST);
                    cap_1   = (grant_q == CH_CORDIC);
                    state_d = ST_ACK_UNIT;
                end
            end
            ST_ACK_UNIT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if ((grant_q == CH_HOST) ? bus.ack_0 : bus.ack_1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= CH_CORDIC;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    d_ff_en #(.W(2*W+1)) u_op_reg (
        .clk (clk),
        .rst (rst),
        .en  (load_op),
        .d   (op_d),
        .q   (op_q)
    );

    d_ff_en #(.W(W+3)) u_res0_reg (
        .clk (clk),
        .rst (rst),
        .en  (cap_0),
        .d   (cap_word),
        .q   (res0_q)
    );

    d_ff_en #(.W(W+3)) u_res1_reg (
        .clk (clk),
        .rst (rst),
        .en  (cap_1),
        .d   (cap_word),
        .q   (res1_q)
    );

    assign {bus.add_subt, bus.data_x, bus.data_y}         = op_q;
    assign {bus.result_0, bus.ovf_0, bus.unf_0, bus.err_0} = res0_q;
    assign {bus.result_1, bus.ovf_1, bus.unf_1, bus.err_1} = res1_q;

    assign bus.beg_fsm = (state_q == ST_START);
    assign bus.rst_fsm = (state_q == ST_ACK_UNIT);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.grant   = grant_q;
    assign bus.ready_0 = (state_q == ST_DONE) && (grant_q == CH_HOST);
    assign bus.ready_1 = (state_q == ST_DONE) && (grant_q == CH_CORDIC);

endmodule

// File: tb/tb_fpu_addsubt_arbiter.sv
// Directed bench for fpu_addsubt_arbiter: the add/subtract unit is played by
// the stimulus, which answers each start with a hand-computed result.
module tb_fpu_addsubt_arbiter;

    localparam int W  = 64;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    fpu_addsubt_arbiter_if #(.W(W)) bus ();

    fpu_addsubt_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.beg_0 = 1'b0;  bus.beg_1 = 1'b0;
        bus.op_0  = 1'b0;  bus.op_1  = 1'b0;
        bus.dataA_0 = '0;  bus.dataB_0 = '0;
        bus.dataA_1 = '0;  bus.dataB_1 = '0;
        bus.ack_0 = 1'b0;  bus.ack_1 = 1'b0;
        bus.ready_unit = 1'b0; bus.ovf_unit = 1'b0; bus.unf_unit = 1'b0;
        bus.result_unit = '0;
    endtask

    // Entered in the START cycle; answers on the delay-th WAIT cycle and
    // returns in the first DONE cycle.
    task automatic serve(input int delay, input logic [63:0] res, input logic ov,
                         input logic un, input string tag);
        check_eq({tag, "_beg_fsm"}, 64'(bus.beg_fsm), 64'd1);
        step();
        check_eq({tag, "_beg_once"}, 64'(bus.beg_fsm), 64'd0);
        for (int i = 1; i < delay; i++) step();
        bus.ready_unit  = 1'b1;
        bus.result_unit = res;
        bus.ovf_unit    = ov;
        bus.unf_unit    = un;
        step();
        bus.ready_unit  = 1'b0;
        bus.result_unit = '0;
        bus.ovf_unit    = 1'b0;
        bus.unf_unit    = 1'b0;
        check_eq({tag, "_rst_fsm"}, 64'(bus.rst_fsm), 64'd1);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
        step();
        check_eq({tag, "_rst_once"}, 64'(bus.rst_fsm), 64'd0);
    endtask

    task automatic ack_ch(input int ch, input string tag);
        if (ch == 0) bus.ack_0 = 1'b1;
        else         bus.ack_1 = 1'b1;
        step();
        bus.ack_0 = 1'b0;
        bus.ack_1 = 1'b0;
        check_eq({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        step();
        check_eq("rst_busy",    64'(bus.busy),     64'd0);
        check_eq("rst_beg_fsm", 64'(bus.beg_fsm),  64'd0);
        check_eq("rst_rst_fsm", 64'(bus.rst_fsm),  64'd0);
        check_eq("rst_ready0",  64'(bus.ready_0),  64'd0);
        check_eq("rst_data_x",  bus.data_x,        64'd0);
        check_eq("rst_result0", bus.result_0,      64'd0);
        check_eq("rst_grant",   64'(bus.grant),    64'd1);
        rst = 1'b1;
        step();

        // Spurious unit response while idle
        bus.ready_unit  = 1'b1;
        bus.result_unit = 64'hDEAD_BEEF_0000_1111;
        bus.ovf_unit    = 1'b1;
        step();
        idle_inputs();
        check_eq("spur_busy",    64'(bus.busy),    64'd0);
        check_eq("spur_result0", bus.result_0,     64'd0);
        check_eq("spur_ovf0",    64'(bus.ovf_0),   64'd0);
        check_eq("spur_ready0",  64'(bus.ready_0), 64'd0);

        // Single host request: 1.0 + 2.0 = 3.0
        bus.beg_0 = 1'b1; bus.op_0 = 1'b0;
        bus.dataA_0 = 64'h3FF0_0000_0000_0000;
        bus.dataB_0 = 64'h4000_0000_0000_0000;
        step();
        bus.beg_0 = 1'b0;
        check_eq("t1_grant",  64'(bus.grant),    64'd0);
        check_eq("t1_data_x", bus.data_x,        64'h3FF0_0000_0000_0000);
        check_eq("t1_data_y", bus.data_y,        64'h4000_0000_0000_0000);
        check_eq("t1_op",     64'(bus.add_subt), 64'd0);
        serve(5, 64'h4008_0000_0000_0000, 1'b0, 1'b0, "t1");
        check_eq("t1_ready0",  64'(bus.ready_0), 64'd1);
        check_eq("t1_ready1",  64'(bus.ready_1), 64'd0);
        check_eq("t1_result0", bus.result_0,     64'h4008_0000_0000_0000);
        check_eq("t1_err0",    64'(bus.err_0),   64'd0);
        ack_ch(0, "t1");
        check_eq("t1_ready0_off", 64'(bus.ready_0), 64'd0);
        check_eq("t1_hold0",      bus.result_0,     64'h4008_0000_0000_0000);

        // Contention straight out of reset: host first, then CORDIC
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.beg_0 = 1'b1; bus.op_0 = 1'b0;
        bus.dataA_0 = 64'h4000_0000_0000_0000;
        bus.dataB_0 = 64'h4010_0000_0000_0000;
        bus.beg_1 = 1'b1; bus.op_1 = 1'b1;
        bus.dataA_1 = 64'h4014_0000_0000_0000;
        bus.dataB_1 = 64'h3FF0_0000_0000_0000;
        step();
        bus.beg_0 = 1'b0;
        check_eq("t2a_grant",  64'(bus.grant), 64'd0);
        check_eq("t2a_data_x", bus.data_x,     64'h4000_0000_0000_0000);
        serve(3, 64'h4018_0000_0000_0000, 1'b0, 1'b1, "t2a");
        check_eq("t2a_ready0",  64'(bus.ready_0), 64'd1);
        check_eq("t2a_unf0",    64'(bus.unf_0),   64'd1);
        check_eq("t2a_result0", bus.result_0,     64'h4018_0000_0000_0000);
        ack_ch(0, "t2a");
        step();
        bus.beg_1 = 1'b0;
        check_eq("t2b_grant",  64'(bus.grant),    64'd1);
        check_eq("t2b_op",     64'(bus.add_subt), 64'd1);
        check_eq("t2b_data_x", bus.data_x,        64'h4014_0000_0000_0000);
        serve(4, 64'h4010_0000_0000_0000, 1'b1, 1'b0, "t2b");
        check_eq("t2b_ready1",  64'(bus.ready_1), 64'd1);
        check_eq("t2b_ready0",  64'(bus.ready_0), 64'd0);
        check_eq("t2b_ovf1",    64'(bus.ovf_1),   64'd1);
        check_eq("t2b_result1", bus.result_1,     64'h4010_0000_0000_0000);
        check_eq("t2b_hold0",   bus.result_0,     64'h4018_0000_0000_0000);
        ack_ch(1, "t2b");
        bus.beg_0 = 1'b1;
        bus.beg_1 = 1'b1;
        step();
        bus.beg_0 = 1'b0;
        bus.beg_1 = 1'b0;
        check_eq("t2c_rr_grant", 64'(bus.grant), 64'd0);

        // That host transaction never gets a unit response
        check_eq("t3_beg_fsm", 64'(bus.beg_fsm), 64'd1);
        repeat (TO) step();
        check_eq("t3_still_wait", 64'(bus.rst_fsm), 64'd0);
        check_eq("t3_busy",       64'(bus.busy),    64'd1);
        step();
        check_eq("t3_rst_fsm", 64'(bus.rst_fsm), 64'd1);
        step();
        check_eq("t3_rst_once", 64'(bus.rst_fsm), 64'd0);
        check_eq("t3_ready0",   64'(bus.ready_0), 64'd1);
        check_eq("t3_err0",     64'(bus.err_0),   64'd1);
        check_eq("t3_result0",  bus.result_0,     64'd0);
        check_eq("t3_unf0",     64'(bus.unf_0),   64'd0);
        ack_ch(0, "t3");

        // CORDIC 9.0 + 2.0 = 11.0, acknowledged late with host waiting
        bus.beg_1 = 1'b1; bus.op_1 = 1'b0;
        bus.dataA_1 = 64'h4022_0000_0000_0000;
        bus.dataB_1 = 64'h4000_0000_0000_0000;
        step();
        bus.beg_1 = 1'b0;
        check_eq("t4_grant", 64'(bus.grant), 64'd1);
        serve(2, 64'h4026_0000_0000_0000, 1'b0, 1'b0, "t4");
        bus.beg_0 = 1'b1; bus.op_0 = 1'b0;
        bus.dataA_0 = 64'h3FF8_0000_0000_0000;
        bus.dataB_0 = 64'h3FF8_0000_0000_0000;
        for (int i = 0; i < 20; i++) begin
            check_eq("t4_ready1",  64'(bus.ready_1), 64'd1);
            check_eq("t4_ready0",  64'(bus.ready_0), 64'd0);
            check_eq("t4_result1", bus.result_1,     64'h4026_0000_0000_0000);
            check_eq("t4_no_beg",  64'(bus.beg_fsm), 64'd0);
            bus.ack_0 = (i == 5);
            step();
        end
        bus.ack_0 = 1'b0;
        bus.ack_1 = 1'b1;
        step();
        bus.ack_1 = 1'b0;
        check_eq("t4_idle",       64'(bus.busy),    64'd0);
        check_eq("t4_ready1_off", 64'(bus.ready_1), 64'd0);
        step();
        check_eq("t4_host_grant", 64'(bus.grant),   64'd0);
        check_eq("t4_host_start", 64'(bus.beg_fsm), 64'd1);
        check_eq("t4_host_dx",    bus.data_x,       64'h3FF8_0000_0000_0000);

        // Reset lands while that host transaction is in WAIT
        bus.beg_0 = 1'b0;
        step();
        step();
        check_eq("t5_busy_wait", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("t5_busy",    64'(bus.busy),    64'd0);
        check_eq("t5_beg_fsm", 64'(bus.beg_fsm), 64'd0);
        check_eq("t5_rst_fsm", 64'(bus.rst_fsm), 64'd0);
        check_eq("t5_data_x",  bus.data_x,       64'd0);
        check_eq("t5_data_y",  bus.data_y,       64'd0);
        check_eq("t5_result1", bus.result_1,     64'd0);
        check_eq("t5_err0",    64'(bus.err_0),   64'd0);
        check_eq("t5_grant",   64'(bus.grant),   64'd1);
        step();
        rst = 1'b1;
        step();
        check_eq("t5_idle", 64'(bus.busy), 64'd0);
        bus.beg_0 = 1'b1;
        step();
        bus.beg_0 = 1'b0;
        check_eq("t5_grant_new", 64'(bus.grant), 64'd0);
        serve(1, 64'h4008_0000_0000_0000, 1'b0, 1'b0, "t5");
        check_eq("t5_ready0",  64'(bus.ready_0), 64'd1);
        check_eq("t5_result0", bus.result_0,     64'h4008_0000_0000_0000);
        ack_ch(0, "t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fpu_addsubt_arbiter.md
FPU_ADDSUBT_ARBITER -- requirements
Module: fpu_addsubt_arbiter

Interface
REQ-001 The module SHALL have parameter W, default 64, giving the IEEE-754 word width (32 or 64).
REQ-002 The module SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles before abort.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have ports beg_0 and beg_1, input, 1 bit each: request level; channel 0 is host, channel 1 is CORDIC.
REQ-006 The module SHALL have ports op_0 and op_1, input, 1 bit each: 0 = add, 1 = subtract.
REQ-007 The module SHALL have ports dataA_0, dataB_0, dataA_1 and dataB_1, input, W bits each: the operands.
REQ-008 The module SHALL have ports ack_0 and ack_1, input, 1 bit each: the requester has consumed its result.
REQ-009 The module SHALL have ports ready_0 and ready_1, output, 1 bit each: the result is valid for that channel.
REQ-010 The module SHALL have ports result_0 and result_1, output, W bits each: the captured result.
REQ-011 The module SHALL have ports ovf_0, unf_0, err_0, ovf_1, unf_1 and err_1, output, 1 bit each: overflow, underflow and timeout flags per channel.
REQ-012 The module SHALL have ports beg_fsm and rst_fsm, output, 1 bit each: start and acknowledge to the add/subtract unit.
REQ-013 The module SHALL have port add_subt, output, 1 bit, and ports data_x and data_y, output, W bits each: the operation and operands to the unit.
REQ-014 The module SHALL have ports ready_unit, ovf_unit and unf_unit, input, 1 bit each, and port result_unit, input, W bits: the unit's responses.
REQ-015 The module SHALL have port busy, output, 1 bit (state is not IDLE), and port grant, output, 1 bit (currently or last served channel).

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT, ACK_UNIT and DONE.
REQ-017 In IDLE with beg_0 or beg_1 high, the module SHALL grant one channel, register its op/dataA/dataB onto add_subt/data_x/data_y, and go to START.
REQ-018 When both requests are high in the same IDLE cycle, the module SHALL grant the channel that is not equal to the last grant (round-robin).
REQ-019 In START, beg_fsm SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT with the timeout counter cleared.
REQ-020 In WAIT, the counter SHALL increment each cycle; on ready_unit=1 the module SHALL capture result_unit, ovf_unit and unf_unit into the granted channel with err=0, and go to ACK_UNIT.
REQ-021 In WAIT, if the counter reaches TIMEOUT without ready_unit, the module SHALL capture result=0, ovf=0, unf=0 and err=1, and go to ACK_UNIT.
REQ-022 In ACK_UNIT, rst_fsm SHALL be high for exactly one cycle, then the FSM SHALL go to DONE.
REQ-023 In DONE, ready_<grant> SHALL stay high and result/flags SHALL stay stable until ack_<grant>=1, after which the FSM SHALL go to IDLE.
REQ-024 Latency: with a request at IDLE cycle 0, beg_fsm SHALL be high in cycle 1; with ready_unit seen in cycle k, rst_fsm SHALL be high in k+1 and ready_<grant> in k+2.
REQ-025 The requester SHALL drop beg_i no later than the cycle it asserts ack_i; a beg_i still high in IDLE is a new request.
REQ-026 The module SHALL ignore ack on the non-granted channel, ready_unit outside WAIT, and beg_i outside IDLE.
REQ-027 A channel's result/flags SHALL hold until that channel is next served; ready of the non-granted channel SHALL be 0.

Reset
REQ-028 On rst=0, asynchronously, the module SHALL set state to IDLE, all outputs to 0 (including data buses and result registers), and the counter to 0.
REQ-029 On rst=0, the last-grant pointer SHALL be set to 1, so channel 0 wins the first contention.
REQ-030 A reset mid-operation SHALL abandon the transaction with no rst_fsm pulse; the unit shares rst.

Structure
REQ-031 Package fpu_arb_pkg SHALL hold the state encoding localparams, CH_HOST=0 and CH_CORDIC=1.
REQ-032 The sub-module arb_timeout_counter (clear, enable, terminal-count output) SHALL implement the WAIT watchdog.
REQ-033 Operand and result registers SHALL use d_ff_en.

Verification
REQ-034 Single request: beg_0=1, op_0=0, dataA=3FF0000000000000, dataB=4000000000000000; unit returns 4008000000000000 after 5 cycles -> beg_fsm in cycle 1, rst_fsm one cycle, ready_0 with result_0=4008000000000000, err_0=0.
REQ-035 Contention: beg_0 and beg_1 both high from reset -> channel 0 served first, then channel 1; next contention serves channel 0.
REQ-036 Timeout: unit never raises ready_unit, TIMEOUT=8 -> after 8 WAIT cycles, err=1, result=0, one rst_fsm pulse, ready asserted.
REQ-037 Delayed ack: ack_1 held low 20 cycles in DONE -> ready_1 and result_1 stable; beg_0 is not granted until after ack_1.
REQ-038 Reset in WAIT: rst=0 mid-WAIT -> all outputs 0 immediately; after release, busy=0 and a new request is accepted normally.
REQ-039 Spurious: ack_0 while channel 1 is in DONE, and ready_unit in IDLE -> no state change.
